gpio_bit_packer: RTL and testbench
==================================

Name: gpio_bit_packer

Overview:
- Downstream consumer of the memory-segmentation stage's GPIO output pair (GPIO data bit plus the GPIOFlag write strobe).
- Each cycle with the strobe high carries one output bit. The block packs these bits MSB-first into WORD_W-bit words and buffers them in a FIFO.
- Words drain through a valid/ready port to the output sink (the testbench file writer or a serial transmitter).
- Partial words are emitted on an explicit flush, tagged with their bit count.

Parameters:
- WORD_W, 8: bits per packed word; range 2..32.
- FIFO_DEPTH, 8: number of buffered words; power of two, at least 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- gpio_flag  in  1  bit strobe; one bit is captured per cycle while high.
- gpio_bit  in  1  data bit, qualified by gpio_flag.
- flush  in  1  single-cycle request to emit a pending partial word.
- out_ready  in  1  sink can accept the head word.
- out_valid  out  1  FIFO non-empty; head word presented.
- out_data  out  WORD_W  head word; partial words right-aligned, unused upper bits 0.
- out_len  out  $clog2(WORD_W+1)  number of valid bits in out_data, 1..WORD_W.
- fifo_level  out  $clog2(FIFO_DEPTH+1)  number of stored words, 0..FIFO_DEPTH.
- overflow  out  1  sticky flag: a word was dropped because the FIFO was full.

Behaviour:
- Reset, asynchronous: shift register, bit_cnt, FIFO pointers, fifo_level and overflow go to 0. As a result out_valid=0, out_data=0, out_len=0. Reset mid-word or with the FIFO non-empty discards all content; nothing is emitted afterwards.
- Collector:
  - shift register sr (WORD_W bits) and bit_cnt (0..WORD_W-1).
  - gpio_flag=1: sr <= {sr[WORD_W-2:0], gpio_bit}.
  - If bit_cnt==WORD_W-1: push {shifted sr, len=WORD_W} and set bit_cnt<=0. Otherwise bit_cnt increments.
  - gpio_bit is ignored while gpio_flag=0.
- Flush:
  - bit_cnt>0, gpio_flag=0: push {sr, len=bit_cnt}; bit_cnt<=0.
  - flush and gpio_flag in the same cycle: the new bit is shifted in first. The resulting word is pushed with len=bit_cnt+1, or len=WORD_W if that bit completes the word. Exactly one push occurs.
  - bit_cnt==0 and gpio_flag=0: flush is a no-op.
- After any push the upper bits of sr are cleared, so partial words are zero-extended.
- FIFO:
  - Registered storage, first-word-fall-through.
  - out_valid = (fifo_level != 0). out_data/out_len come straight from the head entry.
  - A pop occurs when out_valid && out_ready.
  - Head data is held stable while out_valid && !out_ready.
  - Latency: a word pushed in cycle N is visible on out_valid/out_data in cycle N+1.
  - Pointers wrap modulo FIFO_DEPTH.
- Simultaneous events:
  - Push and pop in the same cycle: fifo_level is unchanged. When full, the pop frees the slot first, so the push is accepted and no overflow occurs.
  - Push while full with no pop: the word is dropped, overflow<=1, bit_cnt still resets to 0, and stored contents are untouched.
  - Pop while empty cannot occur because out_valid=0.
- overflow is cleared only by rst.
- fifo_level is registered and is exact every cycle.

Test Plan:
- Reset, then strobe the bits 1,0,1,1,0,0,1,0 on 8 consecutive cycles with out_ready=1 -> one cycle after the 8th bit, out_valid=1, out_data=8'hB2, out_len=8; out_valid=0 the following cycle.
- Strobe 1,1,0, then pulse flush with gpio_flag=0 -> out_data=8'h06, out_len=3, bit_cnt returns to 0; a second flush with no pending bits produces no word.
- Strobe 7 bits of value 1, then on the 8th bit (value 1) assert flush in the same cycle -> exactly one word, 8'hFF with out_len=8; fifo_level=1.
- Hold out_ready=0 and push 9 full words (0x01..0x09) -> fifo_level=8, overflow=1 after the 9th. Then drain with out_ready=1 -> exactly 0x01..0x08 are emitted in order.
- With the FIFO full and out_ready=1, complete a word in the same cycle as a pop -> overflow stays 0, fifo_level stays 8, and the new word is emitted last.
- Push 3 bits, then assert rst asynchronously mid-cycle -> all outputs 0 immediately. After release, 8 new bits 0xA5 give out_data=8'hA5 with no stale bits.

Source files
------------

// File: rtl/gpio_bit_packer.sv
// gpio_bit_packer: packs strobed GPIO bits MSB-first into WORD_W-bit words,
// emits partial words on flush (right-aligned, tagged with their length) and
// buffers the words in a first-word-fall-through FIFO drained by valid/ready.
module gpio_bit_packer #(
   parameter int WORD_W     = 8,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            gpio_flag,
   input  logic                            gpio_bit,
   input  logic                            flush,
   input  logic                            out_ready,
   output logic                            out_valid,
   output logic [WORD_W-1:0]               out_data,
   output logic [$clog2(WORD_W+1)-1:0]     out_len,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
   output logic                            overflow
);

   localparam int CW  = (WORD_W > 2) ? $clog2(WORD_W) : 1;
   localparam int LW  = $clog2(WORD_W + 1);
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int LVW = $clog2(FIFO_DEPTH + 1);

   localparam logic [CW-1:0]  CNT_MAX  = CW'(WORD_W - 1);
   localparam logic [LVW-1:0] LVL_FULL = LVW'(FIFO_DEPTH);

   // collector state
   logic [WORD_W-1:0] r_sr;
   logic [CW-1:0]     r_bit_cnt;

   // FIFO state
   logic [WORD_W-1:0] r_mem_data [FIFO_DEPTH];
   logic [LW-1:0]     r_mem_len  [FIFO_DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [LVW-1:0]    r_level;
   logic              r_overflow;

   logic [WORD_W-1:0] w_sr_shift;
   logic [LW-1:0]     w_cnt_ext;
   logic              w_push;
   logic [WORD_W-1:0] w_push_data;
   logic [LW-1:0]     w_push_len;
   logic              w_valid;
   logic              w_pop;
   logic              w_full;
   logic              w_accept;

   assign w_sr_shift = {r_sr[WORD_W-2:0], gpio_bit};
   assign w_cnt_ext  = LW'(r_bit_cnt);

   // A word is produced when a strobe completes it, when flush coincides with
   // a strobe (the new bit is included), or when flush finds pending bits.
   assign w_push = (gpio_flag && ((r_bit_cnt == CNT_MAX) || flush)) ||
                   (!gpio_flag && flush && (r_bit_cnt != '0));

   // With a strobe the word includes the incoming bit; since sr is cleared
   // after each push, the upper bits of a partial word are already zero.
   assign w_push_data = gpio_flag ? w_sr_shift : r_sr;
   assign w_push_len  = gpio_flag ? (w_cnt_ext + LW'(1)) : w_cnt_ext;

   assign w_valid  = (r_level != '0);
   assign w_pop    = w_valid && out_ready;
   assign w_full   = (r_level == LVL_FULL);
   // A pop in the same cycle frees the slot, so a push into a full FIFO is
   // still accepted when the head is being consumed.
   assign w_accept = w_push && (!w_full || w_pop);

   // Collector: shift in strobed bits, restart cleanly after every push.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sr      <= '0;
         r_bit_cnt <= '0;
      end else if (w_push) begin
         r_sr      <= '0;
         r_bit_cnt <= '0;
      end else if (gpio_flag) begin
         r_sr      <= w_sr_shift;
         r_bit_cnt <= r_bit_cnt + CW'(1);
      end
   end

   // Storage array: written on accepted pushes only, contents need no reset.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_mem_data[r_wr_ptr] <= w_push_data;
         r_mem_len[r_wr_ptr]  <= w_push_len;
      end
   end

   // FIFO bookkeeping: pointers, exact level and sticky overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_accept) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_level <= r_level + LVW'(w_accept) - LVW'(w_pop);
         if (w_push && !w_accept) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // Head entry falls through; outputs read as zero while empty.
   always_comb begin
      out_valid = w_valid;
      out_data  = '0;
      out_len   = '0;
      if (w_valid) begin
         out_data = r_mem_data[r_rd_ptr];
         out_len  = r_mem_len[r_rd_ptr];
      end
   end

   assign fifo_level = r_level;
   assign overflow   = r_overflow;

endmodule

// File: tb/tb_gpio_bit_packer.sv
// Testbench for gpio_bit_packer: directed vectors, a queue-based reference
// model checked every cycle, and literal expectations for key scenarios.
module tb_gpio_bit_packer;

   localparam int W = 8;
   localparam int D = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       gpio_flag = 1'b0;
   logic       gpio_bit = 1'b0;
   logic       flush = 1'b0;
   logic       out_ready = 1'b0;
   logic       out_valid;
   logic [7:0] out_data;
   logic [3:0] out_len;
   logic [3:0] fifo_level;
   logic       overflow;

   int total = 0;
   int bad = 0;

   gpio_bit_packer #(.WORD_W(W), .FIFO_DEPTH(D)) dut (
      .clk        (clk),
      .rst        (rst),
      .gpio_flag  (gpio_flag),
      .gpio_bit   (gpio_bit),
      .flush      (flush),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_len    (out_len),
      .fifo_level (fifo_level),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: bits accumulate as an integer value, words are queued.
   int m_val = 0;
   int m_cnt = 0;
   int m_ovf = 0;
   int q_data[$];
   int q_len[$];

   task automatic m_emit(input int v, input int n);
      if (q_data.size() < D) begin
         q_data.push_back(v);
         q_len.push_back(n);
      end else begin
         m_ovf = 1;
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_val = 0;
         m_cnt = 0;
         m_ovf = 0;
         q_data.delete();
         q_len.delete();
      end else begin
         if (q_data.size() > 0 && out_ready) begin
            void'(q_data.pop_front());
            void'(q_len.pop_front());
         end
         if (gpio_flag) begin
            m_val = m_val * 2 + int'(gpio_bit);
            m_cnt = m_cnt + 1;
            if (m_cnt == W || flush) begin
               m_emit(m_val, m_cnt);
               m_val = 0;
               m_cnt = 0;
            end
         end else if (flush && m_cnt > 0) begin
            m_emit(m_val, m_cnt);
            m_val = 0;
            m_cnt = 0;
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         chk("model_valid", int'(out_valid), int'(q_data.size() != 0));
         if (q_data.size() != 0) begin
            chk("model_data", int'(out_data), q_data[0]);
            chk("model_len", int'(out_len), q_len[0]);
         end
         chk("model_level", int'(fifo_level), q_data.size());
         chk("model_ovf", int'(overflow), m_ovf);
      end
   end

   task automatic step(input logic f, input logic b, input logic fl, input logic rdy);
      gpio_flag = f;
      gpio_bit  = b;
      flush     = fl;
      out_ready = rdy;
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [7:0] w, input logic rdy);
      for (int i = 7; i >= 0; i--) begin
         step(1'b1, w[i], 1'b0, rdy);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
   endtask

   initial begin
      // reset state
      #2;
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_data", int'(out_data), 0);
      chk("rst_len", int'(out_len), 0);
      chk("rst_level", int'(fifo_level), 0);
      chk("rst_ovf", int'(overflow), 0);
      do_reset();

      // full word 1,0,1,1,0,0,1,0
      push_word(8'hB2, 1'b1);
      chk("b2_valid", int'(out_valid), 1);
      chk("b2_data", int'(out_data), 'hB2);
      chk("b2_len", int'(out_len), 8);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("b2_gone", int'(out_valid), 0);

      // partial word 1,1,0 then flush
      step(1'b1, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b1);
      chk("p3_data", int'(out_data), 'h06);
      chk("p3_len", int'(out_len), 3);
      step(1'b0, 1'b0, 1'b1, 1'b1);
      chk("noop_flush_valid", int'(out_valid), 0);
      chk("noop_flush_level", int'(fifo_level), 0);

      // flush coinciding with the completing bit: one word only
      for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b1, 1'b1);
      chk("ff_data", int'(out_data), 'hFF);
      chk("ff_len", int'(out_len), 8);
      chk("ff_level", int'(fifo_level), 1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("ff_single", int'(out_valid), 0);

      // overflow: 9 words into a stalled FIFO
      for (int k = 1; k <= 9; k++) begin
         push_word(8'(k), 1'b0);
         if (k == 8) chk("fill_ovf_before", int'(overflow), 0);
      end
      chk("fill_level", int'(fifo_level), 8);
      chk("fill_ovf", int'(overflow), 1);
      for (int k = 1; k <= 8; k++) begin
         chk("drain_head", int'(out_data), k);
         step(1'b0, 1'b0, 1'b0, 1'b1);
      end
      chk("drain_empty", int'(out_valid), 0);

      // push into full FIFO while popping
      do_reset();
      for (int k = 0; k < 8; k++) push_word(8'(8'h10 + k), 1'b0);
      for (int i = 7; i >= 1; i--) step(1'b1, 1'(8'h18 >> i), 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      chk("pp_ovf", int'(overflow), 0);
      chk("pp_level", int'(fifo_level), 8);
      chk("pp_head", int'(out_data), 'h11);
      for (int k = 1; k <= 8; k++) begin
         chk("pp_drain", int'(out_data), 'h10 + k);
         step(1'b0, 1'b0, 1'b0, 1'b1);
      end
      chk("pp_empty", int'(out_valid), 0);

      // asynchronous reset mid-word with the FIFO non-empty
      push_word(8'h3C, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      chk("pre_arst_valid", int'(out_valid), 1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_valid", int'(out_valid), 0);
      chk("arst_data", int'(out_data), 0);
      chk("arst_len", int'(out_len), 0);
      chk("arst_level", int'(fifo_level), 0);
      chk("arst_ovf", int'(overflow), 0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      rst = 1'b0;
      push_word(8'hA5, 1'b1);
      chk("a5_data", int'(out_data), 'hA5);
      chk("a5_len", int'(out_len), 8);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("a5_single", int'(out_valid), 0);
      step(1'b0, 1'b0, 1'b0, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
